// File: rtl/core_pkg.sv
// Shared fetch constants and helpers: widths, reset PC, bubble instruction, PC alignment.
// Optional perf counters in fetch_stage are enabled with FETCH_PERF_CNT_EN.
package core_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] INST_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_NEXT     = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & INST_ALIGN_MASK;
  endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: imem address/data, IF/ID register outputs and execute redirect.
interface fetch_stage_if;
  import core_pkg::*;

  logic [XLEN-1:0] imem_pc;
  logic [XLEN-1:0] imem_inst;
  logic            id_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_id_valid;
  logic [XLEN-1:0] if_id_inst;
  logic [XLEN-1:0] if_id_pc;
  logic [XLEN-1:0] if_id_pc4;
  logic            misalign_err;

  // IF/ID handshake: the register content transfers to decode on a rising edge
  // where if_id_valid && id_ready && !redirect_valid; redirect drops the content.
  modport master (
    output imem_pc, if_id_valid, if_id_inst, if_id_pc, if_id_pc4, misalign_err,
    input  imem_inst, id_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_pc, if_id_valid, if_id_inst, if_id_pc, if_id_pc4, misalign_err,
    output imem_inst, id_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// Program counter register with redirect / +4 / hold next-PC selection and misalign flag.
module fetch_pc_gen
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  pc_sel_e         pc_sel,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc_q,
  output logic            misalign_err
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      case (pc_sel)
        PC_REDIRECT: begin
          pc_q         <= align_pc(redirect_pc);
          misalign_err <= |redirect_pc[1:0];
        end
        // Wraps modulo 2^XLEN by construction.
        PC_NEXT: pc_q <= pc_q + XLEN'(4);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, captures combinational imem output into IF/ID.
// Define FETCH_PERF_CNT_EN to add saturating fetch/stall event counters.
module fetch_stage
  import core_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  fetch_stage_if.master      bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  logic [XLEN-1:0] pc_q;
  logic            load;
  pc_sel_e         pc_sel;

  assign load = !bus.if_id_valid || bus.id_ready;

  always_comb begin
    pc_sel = PC_HOLD;
    if (bus.redirect_valid) pc_sel = PC_REDIRECT;
    else if (load)          pc_sel = PC_NEXT;
  end

  fetch_pc_gen u_pc_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_sel       (pc_sel),
    .redirect_pc  (bus.redirect_pc),
    .pc_q         (pc_q),
    .misalign_err (bus.misalign_err)
  );

  assign bus.imem_pc = pc_q;

  // imem is combinational, so the instruction at pc_q is captured on the edge that advances pc_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.if_id_valid <= 1'b0;
      bus.if_id_inst  <= NOP_INST;
      bus.if_id_pc    <= '0;
      bus.if_id_pc4   <= '0;
    end else begin
      case (pc_sel)
        PC_REDIRECT: begin
          bus.if_id_valid <= 1'b0;
          bus.if_id_inst  <= NOP_INST;
        end
        PC_NEXT: begin
          bus.if_id_valid <= 1'b1;
          bus.if_id_inst  <= bus.imem_inst;
          bus.if_id_pc    <= pc_q;
          bus.if_id_pc4   <= pc_q + XLEN'(4);
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (pc_sel == PC_NEXT && perf_fetch_cnt != 32'hFFFF_FFFF)
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (pc_sel == PC_HOLD && perf_stall_cnt != 32'hFFFF_FFFF)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: imem stub returns inst = PC; consumed IF/ID
// entries are checked against an expected-PC queue, per-scenario checks are inline.
module tb_fetch_stage;
  import core_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] exp_pc;

  fetch_stage_if bus ();
  assign bus.imem_inst = bus.imem_pc;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
  int          exp_fetch;
  int          exp_stall;
`endif

  fetch_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  // Inputs change 1ns after a rising edge, so the falling edge sees what the next rising edge acts on.
  always @(negedge clk) begin
    if (rst_n && !bus.redirect_valid && bus.if_id_valid && bus.id_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow got_pc=%h exp=none", bus.if_id_pc);
      end else begin
        exp_pc = exp_q.pop_front();
        if (bus.if_id_pc !== exp_pc || bus.if_id_inst !== exp_pc || bus.if_id_pc4 !== exp_pc + 32'd4) begin
          failures++;
          $display("FAIL sb_consume got pc=%h inst=%h pc4=%h exp pc=%h inst=%h pc4=%h",
                   bus.if_id_pc, bus.if_id_inst, bus.if_id_pc4, exp_pc, exp_pc, exp_pc + 32'd4);
        end
      end
    end
`ifdef FETCH_PERF_CNT_EN
    if (!rst_n) begin
      exp_fetch = 0;
      exp_stall = 0;
    end else if (!bus.redirect_valid) begin
      if (!bus.if_id_valid || bus.id_ready) exp_fetch++;
      else exp_stall++;
    end
`endif
  end

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.id_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    repeat (2) step();
    checks++; if (bus.imem_pc !== RESET_PC) begin failures++; $display("FAIL reset_imem_pc got=%h exp=%h", bus.imem_pc, RESET_PC); end
    checks++; if (bus.if_id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.if_id_valid); end
    checks++; if (bus.if_id_inst !== 32'h13) begin failures++; $display("FAIL reset_inst got=%h exp=00000013", bus.if_id_inst); end
    checks++; if (bus.if_id_pc !== 32'h0 || bus.if_id_pc4 !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h/%h exp=0/0", bus.if_id_pc, bus.if_id_pc4); end
    checks++; if (bus.misalign_err !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%b exp=0", bus.misalign_err); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin failures++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_fetch_cnt, perf_stall_cnt); end
`endif
    bus.id_ready = 1'b1;
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [XLEN-1:0] p;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    for (int i = 0; i < 4; i++) begin
      step();
      p = 32'(i * 4);
      checks++;
      if (bus.if_id_valid !== 1'b1 || bus.if_id_pc !== p || bus.if_id_inst !== p || bus.if_id_pc4 !== p + 32'd4 || bus.imem_pc !== p + 32'd4) begin
        failures++;
        $display("FAIL stream_%0d got v=%b pc=%h inst=%h pc4=%h imem=%h exp pc=%h", i,
                 bus.if_id_valid, bus.if_id_pc, bus.if_id_inst, bus.if_id_pc4, bus.imem_pc, p);
      end
      checks++; if (bus.misalign_err !== 1'b0) begin failures++; $display("FAIL stream_misalign_%0d got=%b exp=0", i, bus.misalign_err); end
    end
  endtask

  task automatic test_stall();
    bus.id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.if_id_valid !== 1'b1 || bus.if_id_pc !== 32'hC || bus.if_id_inst !== 32'hC || bus.imem_pc !== 32'h10) begin
        failures++;
        $display("FAIL stall_hold_%0d got v=%b pc=%h inst=%h imem=%h exp v=1 pc=c inst=c imem=10", i,
                 bus.if_id_valid, bus.if_id_pc, bus.if_id_inst, bus.imem_pc);
      end
    end
    exp_q.push_back(32'hC);
    bus.id_ready = 1'b1;
    step();
    checks++;
    if (bus.if_id_pc !== 32'h10 || bus.imem_pc !== 32'h14) begin
      failures++;
      $display("FAIL stall_release got pc=%h imem=%h exp pc=10 imem=14", bus.if_id_pc, bus.imem_pc);
    end
  endtask

  task automatic test_redirect_stall();
    bus.id_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h100;
    step();
    bus.redirect_valid = 1'b0;
    checks++;
    if (bus.if_id_valid !== 1'b0 || bus.if_id_inst !== 32'h13 || bus.imem_pc !== 32'h100 || bus.misalign_err !== 1'b0) begin
      failures++;
      $display("FAIL redirect_bubble got v=%b inst=%h imem=%h mis=%b exp v=0 inst=13 imem=100 mis=0",
               bus.if_id_valid, bus.if_id_inst, bus.imem_pc, bus.misalign_err);
    end
    step();
    checks++;
    if (bus.if_id_valid !== 1'b1 || bus.if_id_pc !== 32'h100 || bus.if_id_inst !== 32'h100 || bus.imem_pc !== 32'h104) begin
      failures++;
      $display("FAIL redirect_target got v=%b pc=%h inst=%h imem=%h exp v=1 pc=100 inst=100 imem=104",
               bus.if_id_valid, bus.if_id_pc, bus.if_id_inst, bus.imem_pc);
    end
  endtask

  task automatic test_misalign();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h202;
    step();
    bus.redirect_valid = 1'b0;
    checks++;
    if (bus.misalign_err !== 1'b1 || bus.imem_pc !== 32'h200 || bus.if_id_valid !== 1'b0) begin
      failures++;
      $display("FAIL misalign_pulse got mis=%b imem=%h v=%b exp mis=1 imem=200 v=0", bus.misalign_err, bus.imem_pc, bus.if_id_valid);
    end
    step();
    checks++;
    if (bus.misalign_err !== 1'b0 || bus.if_id_pc !== 32'h200 || bus.if_id_valid !== 1'b1) begin
      failures++;
      $display("FAIL misalign_clear got mis=%b pc=%h v=%b exp mis=0 pc=200 v=1", bus.misalign_err, bus.if_id_pc, bus.if_id_valid);
    end
  endtask

  task automatic test_wrap();
    bus.id_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    checks++;
    if (bus.imem_pc !== 32'hFFFF_FFFC || bus.if_id_valid !== 1'b0 || bus.misalign_err !== 1'b0) begin
      failures++;
      $display("FAIL wrap_redirect got imem=%h v=%b mis=%b exp imem=fffffffc v=0 mis=0", bus.imem_pc, bus.if_id_valid, bus.misalign_err);
    end
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    step();
    checks++;
    if (bus.if_id_pc !== 32'hFFFF_FFFC || bus.if_id_pc4 !== 32'h0 || bus.imem_pc !== 32'h0 || bus.if_id_valid !== 1'b1) begin
      failures++;
      $display("FAIL wrap_last got pc=%h pc4=%h imem=%h v=%b exp pc=fffffffc pc4=0 imem=0 v=1",
               bus.if_id_pc, bus.if_id_pc4, bus.imem_pc, bus.if_id_valid);
    end
    step();
    checks++;
    if (bus.if_id_pc !== 32'h0 || bus.if_id_pc4 !== 32'h4 || bus.imem_pc !== 32'h4 || bus.misalign_err !== 1'b0) begin
      failures++;
      $display("FAIL wrap_zero got pc=%h pc4=%h imem=%h mis=%b exp pc=0 pc4=4 imem=4 mis=0",
               bus.if_id_pc, bus.if_id_pc4, bus.imem_pc, bus.misalign_err);
    end
    step();
  endtask

  task automatic test_async_reset();
    bus.id_ready = 1'b0;
    step();
    checks++;
    if (bus.if_id_valid !== 1'b1 || bus.if_id_pc !== 32'h4 || bus.imem_pc !== 32'h8) begin
      failures++;
      $display("FAIL pre_reset_hold got v=%b pc=%h imem=%h exp v=1 pc=4 imem=8", bus.if_id_valid, bus.if_id_pc, bus.imem_pc);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (perf_fetch_cnt !== 32'(exp_fetch) || perf_stall_cnt !== 32'(exp_stall)) begin
      failures++;
      $display("FAIL perf_counts got fetch=%0d stall=%0d exp fetch=%0d stall=%0d", perf_fetch_cnt, perf_stall_cnt, exp_fetch, exp_stall);
    end
`endif
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.if_id_valid !== 1'b0 || bus.imem_pc !== RESET_PC || bus.if_id_inst !== 32'h13 || bus.if_id_pc !== 32'h0) begin
      failures++;
      $display("FAIL async_reset got v=%b imem=%h inst=%h pc=%h exp v=0 imem=0 inst=13 pc=0",
               bus.if_id_valid, bus.imem_pc, bus.if_id_inst, bus.if_id_pc);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
      failures++;
      $display("FAIL async_reset_perf got=%0d/%0d exp=0/0", perf_fetch_cnt, perf_stall_cnt);
    end
`endif
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.if_id_valid !== 1'b1 || bus.if_id_pc !== RESET_PC || bus.imem_pc !== RESET_PC + 32'd4) begin
      failures++;
      $display("FAIL post_reset_first got v=%b pc=%h imem=%h exp v=1 pc=0 imem=4", bus.if_id_valid, bus.if_id_pc, bus.imem_pc);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_stall();
    test_misalign();
    test_wrap();
    test_async_reset();
    repeat (2) step();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got=%0d pending exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
